// File: rtl/ps2_ascii_decoder_if.sv
// Scan-code / ASCII FIFO bus for ps2_ascii_decoder.
// keycode/kflag : scan-code word and one-cycle strobe from the PS/2 receiver
// rd_en         : pop request from the downstream consumer
// ascii_data    : FIFO head entry, ascii_valid = FIFO not empty
// fifo_full, overflow, shift_state, caps_state : status
interface ps2_ascii_decoder_if;
  logic [15:0] keycode;
  logic        kflag;
  logic        rd_en;
  logic [7:0]  ascii_data;
  logic        ascii_valid;
  logic        fifo_full;
  logic        overflow;
  logic        shift_state;
  logic        caps_state;

  modport master (
    output keycode, kflag, rd_en,
    input  ascii_data, ascii_valid, fifo_full, overflow, shift_state, caps_state
  );

  modport slave (
    input  keycode, kflag, rd_en,
    output ascii_data, ascii_valid, fifo_full, overflow, shift_state, caps_state
  );
endinterface

// File: rtl/ps2_ascii_decoder.sv
// PS/2 Scan Code Set 2 to ASCII decoder with a first-word-fall-through FIFO.
// clk, rst_n : system clock, asynchronous active-low reset
// bus        : ps2_ascii_decoder_if slave (scan-code input, FIFO read side, status)
module ps2_ascii_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input logic                clk,
  input logic                rst_n,
  ps2_ascii_decoder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  localparam logic [FIFO_AW:0] Depth = (FIFO_AW + 1)'(FIFO_DEPTH);

  state_e state_q, state_d;
  logic [7:0] code;
  logic       unused_prev;
  logic       make_ev, brk_ev, ext_make_ev;

  assign code        = bus.keycode[7:0];
  assign unused_prev = ^bus.keycode[15:8];

  // Prefix FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Prefix FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus.kflag) begin
      case (state_q)
        StIdle: begin
          if (code == 8'hE0)      state_d = StExt;
          else if (code == 8'hF0) state_d = StBrk;
          else                    state_d = StIdle;
        end
        StExt:   state_d = (code == 8'hF0) ? StExtBrk : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Prefix FSM: completed-code events (extended breaks need no action)
  always_comb begin
    make_ev     = 1'b0;
    brk_ev      = 1'b0;
    ext_make_ev = 1'b0;
    if (bus.kflag) begin
      case (state_q)
        StIdle:  make_ev     = (code != 8'hE0) && (code != 8'hF0);
        StExt:   ext_make_ev = (code != 8'hF0);
        StBrk:   brk_ev      = 1'b1;
        default: ;
      endcase
    end
  end

  // Modifiers
  logic lsh_q, lsh_d, rsh_q, rsh_d, caps_q, caps_d, caps_held_q, caps_held_d;
  logic shift;

  assign shift = lsh_q | rsh_q;

  always_comb begin
    lsh_d       = lsh_q;
    rsh_d       = rsh_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (make_ev || brk_ev) begin
      case (code)
        8'h12: lsh_d = make_ev;
        8'h59: rsh_d = make_ev;
        8'h58: begin
          // Toggle only on the first make so typematic repeats are ignored
          if (make_ev && !caps_held_q) caps_d = ~caps_q;
          caps_held_d = make_ev;
        end
        default: ;
      endcase
    end
  end

  // Translation, using modifier state from before this byte
  logic [7:0] ltr, dig_u, dig_s, tr_char;
  logic       tr_hit;

  always_comb begin
    ltr   = 8'h00;
    dig_u = 8'h00;
    dig_s = 8'h00;
    case (code)
      8'h1C: ltr = "a";  8'h32: ltr = "b";  8'h21: ltr = "c";  8'h23: ltr = "d";
      8'h24: ltr = "e";  8'h2B: ltr = "f";  8'h34: ltr = "g";  8'h33: ltr = "h";
      8'h43: ltr = "i";  8'h3B: ltr = "j";  8'h42: ltr = "k";  8'h4B: ltr = "l";
      8'h3A: ltr = "m";  8'h31: ltr = "n";  8'h44: ltr = "o";  8'h4D: ltr = "p";
      8'h15: ltr = "q";  8'h2D: ltr = "r";  8'h1B: ltr = "s";  8'h2C: ltr = "t";
      8'h3C: ltr = "u";  8'h2A: ltr = "v";  8'h1D: ltr = "w";  8'h22: ltr = "x";
      8'h35: ltr = "y";  8'h1A: ltr = "z";
      default: ltr = 8'h00;
    endcase
    case (code)
      8'h45: begin dig_u = "0"; dig_s = ")"; end
      8'h16: begin dig_u = "1"; dig_s = "!"; end
      8'h1E: begin dig_u = "2"; dig_s = "@"; end
      8'h26: begin dig_u = "3"; dig_s = "#"; end
      8'h25: begin dig_u = "4"; dig_s = "$"; end
      8'h2E: begin dig_u = "5"; dig_s = "%"; end
      8'h36: begin dig_u = "6"; dig_s = "^"; end
      8'h3D: begin dig_u = "7"; dig_s = "&"; end
      8'h3E: begin dig_u = "8"; dig_s = "*"; end
      8'h46: begin dig_u = "9"; dig_s = "("; end
      default: begin dig_u = 8'h00; dig_s = 8'h00; end
    endcase

    tr_hit  = 1'b1;
    tr_char = 8'h00;
    if (ltr != 8'h00) begin
      tr_char = (shift ^ caps_q) ? (ltr - 8'h20) : ltr;
    end else if (dig_u != 8'h00) begin
      tr_char = shift ? dig_s : dig_u;
    end else begin
      case (code)
        8'h29:   tr_char = 8'h20;
        8'h5A:   tr_char = 8'h0D;
        8'h66:   tr_char = 8'h08;
        default: tr_hit  = 1'b0;
      endcase
    end
  end

  logic       wr_req_q, wr_req_d;
  logic [7:0] wr_char_q, wr_char_d;

  assign wr_req_d  = (make_ev && tr_hit) || (ext_make_ev && (code == 8'h5A));
  assign wr_char_d = ext_make_ev ? 8'h0D : tr_char;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsh_q       <= 1'b0;
      rsh_q       <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      wr_req_q    <= 1'b0;
      wr_char_q   <= 8'h00;
    end else begin
      lsh_q       <= lsh_d;
      rsh_q       <= rsh_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      wr_req_q    <= wr_req_d;
      wr_char_q   <= wr_char_d;
    end
  end

  // FIFO
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               ovf_q;
  logic               empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == Depth);
  assign pop   = bus.rd_en && !empty;
  // A full FIFO still accepts a write when a pop frees a slot in the same cycle
  assign push  = wr_req_q && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      if (push && !pop)      count_q <= count_q + (FIFO_AW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (FIFO_AW + 1)'(1);
      if (wr_req_q && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_char_q;
  end

  assign bus.ascii_data  = empty ? 8'h00 : mem_q[rptr_q];
  assign bus.ascii_valid = !empty;
  assign bus.fifo_full   = full;
  assign bus.overflow    = ovf_q;
  assign bus.shift_state = shift;
  assign bus.caps_state  = caps_q;

endmodule

// File: doc/ps2_ascii_decoder.md
Name: ps2_ascii_decoder

Overview:
- Consumes the scan-code stream from the PS/2 receiver stage: a 16-bit {previous byte, current byte} word plus a one-cycle strobe.
- Decodes Scan Code Set 2 using its own prefix tracking (E0 extended, F0 break).
- Maintains shift and caps-lock state, translates make codes to ASCII, and buffers the characters in a small FIFO.
- Downstream consumers (UART TX, display writer) read the FIFO via a read-enable handshake.

Parameters:
- FIFO_DEPTH, 8, number of ASCII entries buffered; must be a power of 2.
- FIFO_AW, 3, pointer width; log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst_n  input  1  asynchronous active-low reset.
- keycode  input  16  [15:8] previous byte, [7:0] current byte; only [7:0] is used.
- kflag  input  1  one-cycle strobe, synchronous to clk; keycode[7:0] is valid in that cycle.
- rd_en  input  1  pop the head entry; ignored when FIFO is empty.
- ascii_data  output  8  FIFO head entry; valid while ascii_valid=1.
- ascii_valid  output  1  FIFO not empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky; set when a character is dropped because the FIFO is full.
- shift_state  output  1  left shift (12) or right shift (59) currently held.
- caps_state  output  1  caps-lock toggle state.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty: ascii_valid=0, fifo_full=0, ascii_data=0.
  - overflow=0, shift_state=0, caps_state=0.
  - Prefix FSM in IDLE; internal held flags cleared.
  - Mid-operation reset discards any partial prefix and all buffered data.
- Prefix FSM (advances only on kflag=1):
  - States: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make code -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make -> IDLE.
  - BRK: any byte is a break code -> IDLE.
  - EXT_BRK: any byte is an extended break -> IDLE.
  - E1 and all unlisted bytes in IDLE are treated as make codes with no mapping, so they are ignored.
- Modifier tracking:
  - Make 12 or 59 sets the corresponding held bit; the matching break clears it.
  - shift_state = OR of the two held bits.
  - Make 58 toggles caps_state only if caps_held=0, then sets caps_held; break 58 clears caps_held, so typematic repeat does not re-toggle.
  - Extended codes never affect the modifiers.
- Translation (non-extended make codes only):
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Letter case: uppercase (0x41-0x5A) when shift_state XOR caps_state, else lowercase (0x61-0x7A).
  - Digits: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
  - With shift held, digits map to ) ! @ # $ % ^ & * ( respectively; caps_state has no effect on digits.
  - 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08.
  - Extended make E0 5A -> 0x0D.
  - All other make codes, all break codes and all other extended codes produce no output.
  - Shift state used is the value before the current byte is applied.
- Latency:
  - The byte is sampled at the clk edge where kflag=1 (edge N); the decoded character and its write-request flag are registered at edge N.
  - The FIFO write occurs at edge N+1; ascii_valid is high after edge N+1 when the FIFO was empty.
  - Typematic repeats of make codes each produce one character.
- FIFO (first-word-fall-through):
  - ascii_data always reflects the head entry.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with an FAW+1-bit count.
  - rd_en with ascii_valid=1 pops at the edge.
- FIFO boundary conditions:
  - Write while full and no pop: the character is dropped, overflow is set and held until reset, and FIFO contents are unchanged.
  - Write while full with a pop in the same cycle: both occur, count unchanged, no overflow.
  - Write while empty with rd_en=1: only the write occurs; there is no bypass.
- kflag pulses closer than 2 cycles apart are not expected from upstream and are not required to work.

Test Plan:
- Reset, then make 1C, F0 1C (kflag pulses 10 cycles apart) -> one entry 0x61, ascii_valid 2 edges after the first kflag, no entry for the break.
- 12, 1C, F0 12, 1C -> entries 0x41 then 0x61; shift_state 1 between the 12 make and the F0 12 break.
- 58, 58 (typematic), F0 58, then 1C; 58, F0 58, then 16 -> caps_state 1 after the first pair, first 1C gives 0x41; second toggle clears caps_state; 16 gives 0x31.
- E0 5A, E0 F0 5A, E0 75, then 59 + 16 -> entries 0x0D then 0x21 only; E0 75 produces nothing.
- 9 letter makes with rd_en=0 -> fifo_full after the 8th write, 9th dropped, overflow=1; then pop 8 times -> ascii_valid=0, overflow stays 1.
- rst_n low mid-stream (after E0, FIFO holding 3 entries) -> outputs cleared asynchronously; the following byte 1C decodes as a plain make giving 0x61.
